s2p_align_rx: RTL and testbench
===============================

# s2p_align_rx

Serial receiver front end for the 1-bit lane link. It hunts the incoming bit stream for the comma byte and fixes the byte boundary once enough consecutive commas arrive. It then deserializes comma-delimited 4-byte words onto four 8-bit output lanes with a one-cycle valid strobe. It is the receive end of the comma-framed serial link driven by the team's parallel-to-serial transmitter, which sends a comma before every word and idle commas otherwise.

## Interface
- COMMA, 8'hBC, sync/idle byte value.
- LOCK_CNT, 4, consecutive aligned commas required to declare lock (range 2–15).
- LOSS_CNT, 3, consecutive missing-comma errors that drop lock (range 1–15).

- IN_CLK  input  1  sole clock; all logic on rising edge.
- IN_RESET  input  1  asynchronous, active-low reset.
- IN_ENB  input  1  synchronous enable; low forces HUNT.
- IN_DATA  input  1  serial bit, MSB of each byte first.
- OUT_LANE0  output  8  first data byte of last complete word.
- OUT_LANE1  output  8  second data byte.
- OUT_LANE2  output  8  third data byte.
- OUT_LANE3  output  8  fourth data byte.
- OUT_VALID  output  1  one-cycle strobe: lanes updated this cycle.
- OUT_SYNC  output  1  high while in LOCKED.

## Operation
- Shift register: 8-bit SR ← {SR[6:0], IN_DATA} every enabled cycle. Candidate byte B = {SR[6:0], IN_DATA}, the value including the bit sampled this edge.
- Bit counter BC is 3-bit and wraps 7→0. A byte completes on an edge where BC == 7.
- State HUNT:
  - BC is ignored.
  - When B == COMMA, go to SYNC with comma count CC = 1 and BC = 0.
- State SYNC:
  - At byte completion, if B == COMMA: CC++. If CC reaches LOCK_CNT, go to LOCKED with IDX = 0 and ERR = 0.
  - At byte completion, if B != COMMA: go to HUNT with CC = 0.
- State LOCKED, at byte completion:
  - B == COMMA: IDX = 0, ERR = 0. Any partial word is discarded and no strobe is issued.
  - B != COMMA and IDX < 4: store B into lane IDX, then IDX++. If IDX was 3, all four lanes are updated together and OUT_VALID = 1.
  - B != COMMA and IDX == 4 (comma expected): the byte is dropped and ERR++. When ERR reaches LOSS_CNT, go to HUNT with CC = 0.
- Staging: data bytes are held in internal staging registers. OUT_LANE0..3 load all at once on word completion, so the outputs never show a partial word.
- Lane hold: OUT_LANEx hold their value until the next complete word, including across loss of lock and IN_ENB low.
- IN_ENB low:
  - SR, BC, CC, IDX, ERR and the staging registers clear.
  - State goes to HUNT; OUT_VALID = 0 and OUT_SYNC = 0.
  - OUT_LANEx hold their value.
- Counters saturate only at their terminal conditions above; none overflows.

## Timing
- Reset (IN_RESET = 0): state HUNT, and all of the following clear immediately and asynchronously:
  - SR, BC, CC, IDX, ERR and the staging registers;
  - OUT_LANE0..3 = 8'h00;
  - OUT_VALID = 0 and OUT_SYNC = 0.
- Reset release: the first sampled bit is on the first rising edge after IN_RESET goes high.
- HUNT detection: a comma is detected on the same edge that samples its 8th bit. BC = 0 on the next edge, so the next byte's first bit is the bit sampled on that next edge.
- OUT_SYNC rises on the edge that samples the last bit of the LOCK_CNT-th comma.
- OUT_SYNC falls on the edge that samples the last bit of the LOSS_CNT-th erroneous byte.
- OUT_VALID and OUT_LANEx are registered. They change on the edge that samples bit 8 of the fourth data byte and are visible during the following cycle.
- Minimum spacing of OUT_VALID strobes is 40 cycles (comma + 4 bytes).
- Simultaneous events:
  - IN_ENB low on a word-completion edge: IN_ENB wins. There is no strobe and the lanes hold.
  - Reset beats everything.
- Reset mid-word: the partial word is lost and the lanes return to 0.

## Test plan
- Reset: assert IN_RESET = 0 mid-stream → all outputs read 0 asynchronously (without waiting for a clock edge). OUT_SYNC = 0 and OUT_VALID = 0 after release.
- Lock at arbitrary offset: 3 junk bits 3'b101, then 4× 8'hBC → OUT_SYNC rises on the edge sampling bit 8 of the 4th comma. It is not high after the 3rd.
- Word transfer: locked, send BC,11,22,33,44 → one OUT_VALID pulse, LANE0..3 = 11,22,33,44. The lanes hold through 10 idle commas, with no further strobes.
- Comma mid-word: locked, send BC,AA,BB,BC,01,02,03,04 → exactly one strobe, lanes = 01,02,03,04. AA and BB never appear on the outputs.
- Loss of lock: locked after a word, send 3 non-comma bytes 55,66,77 → no strobe. OUT_SYNC falls on the 3rd byte's last bit. Lanes keep the prior word. Then 4 commas → relock.
- Enable drop: during word bytes, IN_ENB = 0 for 1 cycle → OUT_SYNC = 0 the next cycle, no strobe, lanes hold. Relock then requires LOCK_CNT new commas.

Source files
------------

// File: rtl/s2p_align_rx_if.sv
// Parallel-side bundle of the comma-aligned serial receiver: serial input
// with enable on one side, four byte lanes plus valid/sync status on the other.
interface s2p_align_rx_if;
  logic       IN_ENB;
  logic       IN_DATA;
  logic [7:0] OUT_LANE0;
  logic [7:0] OUT_LANE1;
  logic [7:0] OUT_LANE2;
  logic [7:0] OUT_LANE3;
  logic       OUT_VALID;
  logic       OUT_SYNC;

  // Driver of the serial stream / consumer of the words
  modport master (
    output IN_ENB,
    output IN_DATA,
    input  OUT_LANE0,
    input  OUT_LANE1,
    input  OUT_LANE2,
    input  OUT_LANE3,
    input  OUT_VALID,
    input  OUT_SYNC
  );

  // The receiver itself
  modport slave (
    input  IN_ENB,
    input  IN_DATA,
    output OUT_LANE0,
    output OUT_LANE1,
    output OUT_LANE2,
    output OUT_LANE3,
    output OUT_VALID,
    output OUT_SYNC
  );
endinterface

// File: rtl/s2p_align_rx.sv
// Comma-aligned serial-to-parallel receiver for the 1-bit lane link.
// Hunts for the comma byte at any bit offset, locks the byte boundary after
// LOCK_CNT aligned commas, then assembles comma-delimited 4-byte words.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_HUNT   | sliding bit-by-bit search for a comma at any offset
//   ST_SYNC   | boundary tentatively fixed, counting consecutive commas
//   ST_LOCKED | boundary trusted, collecting data bytes into words
module s2p_align_rx #(
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         LOCK_CNT = 4,
  parameter int         LOSS_CNT = 3
) (
  input  logic             IN_CLK,
  input  logic             IN_RESET,
  s2p_align_rx_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

  state_t     state_q;
  logic [7:0] sr_q;
  logic [2:0] bc_q;
  logic [3:0] cc_q;
  logic [2:0] idx_q;
  logic [3:0] err_q;
  logic [7:0] stg_q  [3];
  logic [7:0] lane_q [4];
  logic       valid_q;
  logic       sync_q;

  logic [7:0] sr_d;
  logic       is_comma;
  logic       byte_done;

  // Candidate byte includes the bit sampled on this edge
  always_comb begin
    sr_d      = {sr_q[6:0], bus.IN_DATA};
    is_comma  = (sr_d == COMMA);
    byte_done = (bc_q == 3'd7);
  end

  // Alignment FSM, word assembly and registered outputs
  always_ff @(posedge IN_CLK or negedge IN_RESET) begin
    if (!IN_RESET) begin
      state_q <= ST_HUNT;
      sr_q    <= 8'h00;
      bc_q    <= 3'd0;
      cc_q    <= 4'd0;
      idx_q   <= 3'd0;
      err_q   <= 4'd0;
      for (int i = 0; i < 3; i++) stg_q[i]  <= 8'h00;
      for (int i = 0; i < 4; i++) lane_q[i] <= 8'h00;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
    end else if (!bus.IN_ENB) begin
      // Lanes deliberately keep the last complete word
      state_q <= ST_HUNT;
      sr_q    <= 8'h00;
      bc_q    <= 3'd0;
      cc_q    <= 4'd0;
      idx_q   <= 3'd0;
      err_q   <= 4'd0;
      for (int i = 0; i < 3; i++) stg_q[i] <= 8'h00;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      bc_q    <= bc_q + 3'd1;
      valid_q <= 1'b0;
      case (state_q)
        ST_HUNT: begin
          // Bit count is meaningless while hunting; restart it at a comma
          bc_q <= 3'd0;
          if (is_comma) begin
            state_q <= ST_SYNC;
            cc_q    <= 4'd1;
          end
        end
        ST_SYNC: begin
          if (byte_done) begin
            if (is_comma) begin
              cc_q <= cc_q + 4'd1;
              if (cc_q + 4'd1 == LOCK_C) begin
                state_q <= ST_LOCKED;
                idx_q   <= 3'd0;
                err_q   <= 4'd0;
                sync_q  <= 1'b1;
              end
            end else begin
              state_q <= ST_HUNT;
              cc_q    <= 4'd0;
            end
          end
        end
        ST_LOCKED: begin
          if (byte_done) begin
            if (is_comma) begin
              // A comma always reframes; a partial word is simply abandoned
              idx_q <= 3'd0;
              err_q <= 4'd0;
            end else if (idx_q < 3'd3) begin
              stg_q[idx_q[1:0]] <= sr_d;
              idx_q             <= idx_q + 3'd1;
            end else if (idx_q == 3'd3) begin
              lane_q[0] <= stg_q[0];
              lane_q[1] <= stg_q[1];
              lane_q[2] <= stg_q[2];
              lane_q[3] <= sr_d;
              valid_q   <= 1'b1;
              idx_q     <= 3'd4;
            end else begin
              // Word complete and the comma did not show up
              err_q <= err_q + 4'd1;
              if (err_q + 4'd1 == LOSS_C) begin
                state_q <= ST_HUNT;
                cc_q    <= 4'd0;
                idx_q   <= 3'd0;
                err_q   <= 4'd0;
                sync_q  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= ST_HUNT;
          cc_q    <= 4'd0;
          sync_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping onto the interface
  assign bus.OUT_LANE0 = lane_q[0];
  assign bus.OUT_LANE1 = lane_q[1];
  assign bus.OUT_LANE2 = lane_q[2];
  assign bus.OUT_LANE3 = lane_q[3];
  assign bus.OUT_VALID = valid_q;
  assign bus.OUT_SYNC  = sync_q;

endmodule

// File: tb/tb_s2p_align_rx.sv
// Directed bench for the comma-aligned serial receiver.
module tb_s2p_align_rx;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   vcount;
  bit   seen_bad;

  s2p_align_rx_if bus ();

  s2p_align_rx dut (
    .IN_CLK   (clk),
    .IN_RESET (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counter and watch for bytes that must never reach the lanes
  always @(negedge clk) begin
    if (bus.OUT_VALID === 1'b1) vcount++;
    if (bus.OUT_LANE0 == 8'hAA || bus.OUT_LANE1 == 8'hAA ||
        bus.OUT_LANE2 == 8'hAA || bus.OUT_LANE3 == 8'hAA ||
        bus.OUT_LANE0 == 8'hBB || bus.OUT_LANE1 == 8'hBB ||
        bus.OUT_LANE2 == 8'hBB || bus.OUT_LANE3 == 8'hBB)
      seen_bad = 1'b1;
  end

  // Present one bit, let the next rising edge sample it, settle 1 time unit
  task automatic send_bit(input logic b);
    bus.IN_DATA = b;
    @(posedge clk);
    #1;
  endtask

  // Top n bits of a byte, MSB first
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  function automatic logic [31:0] lanes();
    return {bus.OUT_LANE0, bus.OUT_LANE1, bus.OUT_LANE2, bus.OUT_LANE3};
  endfunction

  // Send four commas, checking SYNC is low after the third and high after the fourth
  task automatic relock(input string name);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    checks++;
    if (bus.OUT_SYNC !== 1'b0) begin
      errors++;
      $display("FAIL %s_sync_after3: got %b expected 0", name, bus.OUT_SYNC);
    end
    send_bits(8'hBC, 7);
    checks++;
    if (bus.OUT_SYNC !== 1'b0) begin
      errors++;
      $display("FAIL %s_sync_bit7: got %b expected 0", name, bus.OUT_SYNC);
    end
    send_bit(1'b0);
    checks++;
    if (bus.OUT_SYNC !== 1'b1) begin
      errors++;
      $display("FAIL %s_sync_after4: got %b expected 1", name, bus.OUT_SYNC);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.IN_ENB  = 1'b1;
    bus.IN_DATA = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (lanes() !== 32'h0) begin
      errors++;
      $display("FAIL reset_lanes: got %h expected 00000000", lanes());
    end
    checks++;
    if (bus.OUT_VALID !== 1'b0 || bus.OUT_SYNC !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b sync=%b expected 0/0", bus.OUT_VALID, bus.OUT_SYNC);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    relock("lock");
  endtask

  task automatic test_word();
    int v0;
    send_byte(8'hBC);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_bits(8'h44, 7);
    checks++;
    if (bus.OUT_VALID !== 1'b0 || lanes() !== 32'h0) begin
      errors++;
      $display("FAIL word_early: got valid=%b lanes=%h expected 0/00000000", bus.OUT_VALID, lanes());
    end
    v0 = vcount;
    send_bit(1'b0);
    checks++;
    if (bus.OUT_VALID !== 1'b1) begin
      errors++;
      $display("FAIL word_valid: got %b expected 1", bus.OUT_VALID);
    end
    checks++;
    if (lanes() !== 32'h11223344) begin
      errors++;
      $display("FAIL word_lanes: got %h expected 11223344", lanes());
    end
    for (int i = 0; i < 10; i++) send_byte(8'hBC);
    checks++;
    if (vcount - v0 !== 1) begin
      errors++;
      $display("FAIL word_strobes: got %0d expected 1", vcount - v0);
    end
    checks++;
    if (lanes() !== 32'h11223344 || bus.OUT_SYNC !== 1'b1) begin
      errors++;
      $display("FAIL word_hold: got lanes=%h sync=%b expected 11223344/1", lanes(), bus.OUT_SYNC);
    end
  endtask

  task automatic test_comma_mid();
    int v0;
    v0 = vcount;
    seen_bad = 1'b0;
    send_byte(8'hBC);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hBC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    checks++;
    if (bus.OUT_VALID !== 1'b1 || lanes() !== 32'h01020304) begin
      errors++;
      $display("FAIL mid_word: got valid=%b lanes=%h expected 1/01020304", bus.OUT_VALID, lanes());
    end
    @(negedge clk);
    #1;
    checks++;
    if (vcount - v0 !== 1) begin
      errors++;
      $display("FAIL mid_strobes: got %0d expected 1", vcount - v0);
    end
    checks++;
    if (seen_bad !== 1'b0) begin
      errors++;
      $display("FAIL mid_partial_leak: got %b expected 0", seen_bad);
    end
  endtask

  task automatic test_loss();
    int v0;
    v0 = vcount;
    send_byte(8'h55);
    send_byte(8'h66);
    send_bits(8'h77, 7);
    checks++;
    if (bus.OUT_SYNC !== 1'b1) begin
      errors++;
      $display("FAIL loss_early: got %b expected 1", bus.OUT_SYNC);
    end
    send_bit(1'b1);
    checks++;
    if (bus.OUT_SYNC !== 1'b0) begin
      errors++;
      $display("FAIL loss_sync: got %b expected 0", bus.OUT_SYNC);
    end
    checks++;
    if (lanes() !== 32'h01020304 || vcount !== v0) begin
      errors++;
      $display("FAIL loss_hold: got lanes=%h strobes=%0d expected 01020304/0", lanes(), vcount - v0);
    end
    relock("loss_relock");
  endtask

  task automatic test_enb_drop();
    int v0;
    v0 = vcount;
    send_byte(8'hBC);
    send_byte(8'h5A);
    send_bits(8'h6B, 3);
    bus.IN_ENB = 1'b0;
    send_bit(1'b1);
    checks++;
    if (bus.OUT_SYNC !== 1'b0 || bus.OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL enb_flags: got sync=%b valid=%b expected 0/0", bus.OUT_SYNC, bus.OUT_VALID);
    end
    bus.IN_ENB = 1'b1;
    relock("enb_relock");
    checks++;
    if (lanes() !== 32'h01020304 || vcount !== v0) begin
      errors++;
      $display("FAIL enb_hold: got lanes=%h strobes=%0d expected 01020304/0", lanes(), vcount - v0);
    end
    send_byte(8'hBC);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_byte(8'hA4);
    checks++;
    if (bus.OUT_VALID !== 1'b1 || lanes() !== 32'hA1A2A3A4) begin
      errors++;
      $display("FAIL enb_newword: got valid=%b lanes=%h expected 1/a1a2a3a4", bus.OUT_VALID, lanes());
    end
  endtask

  task automatic test_enb_on_word_edge();
    send_byte(8'hBC);
    send_byte(8'hB1);
    send_byte(8'hB2);
    send_byte(8'hB3);
    send_bits(8'hB4, 7);
    bus.IN_ENB = 1'b0;
    send_bit(1'b0);
    checks++;
    if (bus.OUT_VALID !== 1'b0 || lanes() !== 32'hA1A2A3A4 || bus.OUT_SYNC !== 1'b0) begin
      errors++;
      $display("FAIL enb_edge: got valid=%b lanes=%h sync=%b expected 0/a1a2a3a4/0",
               bus.OUT_VALID, lanes(), bus.OUT_SYNC);
    end
    bus.IN_ENB = 1'b1;
    relock("edge_relock");
  endtask

  task automatic test_reset_mid();
    send_byte(8'hBC);
    send_byte(8'hC1);
    send_bits(8'hC2, 4);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (lanes() !== 32'h0 || bus.OUT_SYNC !== 1'b0 || bus.OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got lanes=%h sync=%b valid=%b expected 00000000/0/0",
               lanes(), bus.OUT_SYNC, bus.OUT_VALID);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_bit(1'b1);
    checks++;
    if (lanes() !== 32'h0 || bus.OUT_SYNC !== 1'b0 || bus.OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL after_release: got lanes=%h sync=%b valid=%b expected 00000000/0/0",
               lanes(), bus.OUT_SYNC, bus.OUT_VALID);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    vcount   = 0;
    seen_bad = 1'b0;
    test_reset();
    test_lock();
    test_word();
    test_comma_mid();
    test_loss();
    test_enb_drop();
    test_enb_on_word_edge();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
